placar_arbitro_soma: RTL and testbench



---
 rtl/placar_pkg.sv | 25 ++
 rtl/placar_rr_arb.sv | 23 ++
 rtl/placar_arbitro_soma.sv | 193 +++++++++++++++++++
 tb/tb_placar_arbitro_soma.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/placar_pkg.sv
// Shared types and constants for the two-team score arbiter/sequencer.
package placar_pkg;

    localparam int SCORE_W = 7;
    localparam int PTS_W   = 2;

    localparam logic TEAM_A = 1'b0;
    localparam logic TEAM_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A 7-bit carry-out means the true sum already exceeds any legal ceiling
    function automatic logic needs_sat(
        input logic               cout,
        input logic [SCORE_W-1:0] sum,
        input logic [SCORE_W-1:0] max_score
    );
        return cout | (sum > max_score);
    endfunction

endpackage

// File: rtl/placar_rr_arb.sv
// Two-way round-robin picker; purely combinational, pointer register lives in the parent.
module placar_rr_arb
    import placar_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Select a single requester, using the pointer only to break a tie
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = TEAM_A;
        case (req_i)
            2'b01:   gnt_idx_o = TEAM_A;
            2'b10:   gnt_idx_o = TEAM_B;
            2'b11:   gnt_idx_o = prio_i;
            default: gnt_idx_o = TEAM_A;
        endcase
    end

endmodule

// File: rtl/placar_arbitro_soma.sv
// Shares one external score adder between two teams' point requests (IDLE/ADD/DONE).
// Optional PLACAR_ULTIMA_CESTA_EN adds last_team/last_pts/last_valid outputs.
module placar_arbitro_soma
    import placar_pkg::*;
#(
    parameter int MAX_SCORE = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [1:0]         req,
    input  logic [PTS_W-1:0]   pts0,
    input  logic [PTS_W-1:0]   pts1,
    output logic [1:0]         ack,
    output logic               busy,
    output logic [SCORE_W-1:0] add_a,
    output logic [PTS_W-1:0]   add_b,
    output logic               add_cin,
    input  logic [SCORE_W-1:0] add_sum,
    input  logic               add_cout,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
`ifdef PLACAR_ULTIMA_CESTA_EN
    output logic               last_team,
    output logic [PTS_W-1:0]   last_pts,
    output logic               last_valid,
`endif
    output logic [1:0]         sat
);

    localparam logic [SCORE_W-1:0] MAX_C = SCORE_W'(MAX_SCORE);

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               team_q, team_d;
    logic [SCORE_W-1:0] add_a_q, add_a_d;
    logic [PTS_W-1:0]   add_b_q, add_b_d;
    logic [SCORE_W-1:0] res_q, res_d;
    logic               res_sat_q, res_sat_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [1:0]         sat_q, sat_d;
    logic [1:0]         ack_q, ack_d;
    logic               busy_q, busy_d;
`ifdef PLACAR_ULTIMA_CESTA_EN
    logic               last_team_q, last_team_d;
    logic [PTS_W-1:0]   last_pts_q, last_pts_d;
    logic               last_valid_q, last_valid_d;
`endif

    logic gnt_valid_s;
    logic gnt_idx_s;

    placar_rr_arb u_arb (
        .req_i       (req),
        .prio_i      (prio_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    // Next-state and datapath decisions; clr is applied last so it overrides every state
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        team_d    = team_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        res_d     = res_q;
        res_sat_d = res_sat_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        sat_d     = sat_q;
        ack_d     = 2'b00;
        busy_d    = busy_q;
`ifdef PLACAR_ULTIMA_CESTA_EN
        last_team_d  = last_team_q;
        last_pts_d   = last_pts_q;
        last_valid_d = last_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    team_d  = gnt_idx_s;
                    add_a_d = (gnt_idx_s == TEAM_B) ? score1_q : score0_q;
                    add_b_d = (gnt_idx_s == TEAM_B) ? pts1 : pts0;
                    state_d = ADD;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ADD: begin
                res_sat_d = needs_sat(add_cout, add_sum, MAX_C);
                res_d     = res_sat_d ? MAX_C : add_sum;
                ack_d     = (team_q == TEAM_B) ? 2'b10 : 2'b01;
                state_d   = DONE;
                busy_d    = 1'b1;
            end
            DONE: begin
                if (team_q == TEAM_B) begin
                    score1_d = res_q;
                    sat_d[1] = res_sat_q;
                end else begin
                    score0_d = res_q;
                    sat_d[0] = res_sat_q;
                end
                prio_d  = ~team_q;
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef PLACAR_ULTIMA_CESTA_EN
                last_team_d  = team_q;
                last_pts_d   = add_b_q;
                last_valid_d = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort: in-flight op is dropped silently, pointer keeps its position
        if (clr) begin
            state_d  = IDLE;
            score0_d = '0;
            score1_d = '0;
            sat_d    = 2'b00;
            ack_d    = 2'b00;
            busy_d   = 1'b0;
`ifdef PLACAR_ULTIMA_CESTA_EN
            last_valid_d = 1'b0;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= TEAM_A;
            team_q    <= TEAM_A;
            add_a_q   <= '0;
            add_b_q   <= '0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
            score0_q  <= '0;
            score1_q  <= '0;
            sat_q     <= 2'b00;
            ack_q     <= 2'b00;
            busy_q    <= 1'b0;
`ifdef PLACAR_ULTIMA_CESTA_EN
            last_team_q  <= 1'b0;
            last_pts_q   <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            team_q    <= team_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            sat_q     <= sat_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
`ifdef PLACAR_ULTIMA_CESTA_EN
            last_team_q  <= last_team_d;
            last_pts_q   <= last_pts_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = 1'b0;
    assign score0  = score0_q;
    assign score1  = score1_q;
    assign sat     = sat_q;
`ifdef PLACAR_ULTIMA_CESTA_EN
    assign last_team  = last_team_q;
    assign last_pts   = last_pts_q;
    assign last_valid = last_valid_q;
`endif

endmodule

// File: tb/tb_placar_arbitro_soma.sv
// Directed self-checking bench: scoreboard of expected (team, score, sat) per request.
module tb_placar_arbitro_soma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] pts0 = 2'd0, pts1 = 2'd0;
    logic [1:0] ack;
    logic       busy;
    logic [6:0] add_a;
    logic [1:0] add_b;
    logic       add_cin;
    logic [6:0] add_sum;
    logic       add_cout;
    logic [6:0] score0, score1;
    logic [1:0] sat;

    logic [1:0] req_m = 2'b00;
    logic [1:0] pts1_m = 2'd0;
    logic [1:0] ack_m;
    logic       busy_m;
    logic [6:0] add_a_m;
    logic [1:0] add_b_m;
    logic       add_cin_m;
    logic [6:0] add_sum_m;
    logic       add_cout_m;
    logic [6:0] score0_m, score1_m;
    logic [1:0] sat_m;

    always #5 clk = ~clk;

    assign {add_cout, add_sum}     = {1'b0, add_a} + {6'b0, add_b} + {7'b0, add_cin};
    assign {add_cout_m, add_sum_m} = {1'b0, add_a_m} + {6'b0, add_b_m} + {7'b0, add_cin_m};

    placar_arbitro_soma #(.MAX_SCORE(99)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .pts0(pts0), .pts1(pts1),
        .ack(ack), .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .score0(score0), .score1(score1), .sat(sat)
    );

    placar_arbitro_soma #(.MAX_SCORE(127)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .req(req_m), .pts0(2'd0), .pts1(pts1_m),
        .ack(ack_m), .busy(busy_m), .add_a(add_a_m), .add_b(add_b_m), .add_cin(add_cin_m),
        .add_sum(add_sum_m), .add_cout(add_cout_m), .score0(score0_m), .score1(score1_m), .sat(sat_m)
    );

    typedef struct {
        int         team;
        int         score;
        logic [1:0] sat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m0 = 0, m1 = 0;
    logic [1:0] msat = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of one update on the MAX_SCORE=99 instance; pushes the expectation
    task automatic model_push(input int t, input int p);
        exp_t e;
        int   s;
        s = ((t == 1) ? m1 : m0) + p;
        msat[t] = (s > 99);
        if (s > 99) s = 99;
        if (t == 1) m1 = s; else m0 = s;
        e.team = t; e.score = s; e.sat = msat;
        sb.push_back(e);
    endtask

    task automatic wait_ack(output logic [1:0] a, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack == 2'b00 && lat < 12);
        a = ack;
    endtask

    task automatic pop_check(input logic [1:0] a);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("ack_team", a, (e.team == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            check("score", (e.team == 1) ? score1 : score0, e.score);
            check("sat", sat, e.sat);
            check("ack_pulse", ack, 2'b00);
        end
    endtask

    task automatic serve(input int t, input logic [1:0] p);
        logic [1:0] a;
        int         lat;
        model_push(t, p);
        if (t == 1) pts1 = p; else pts0 = p;
        req[t] = 1'b1;
        wait_ack(a, lat);
        check("latency", lat, 2);
        req[t] = 1'b0;
        pop_check(a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        req_m = 2'b00;
        clr = 1'b0;
        m0 = 0; m1 = 0; msat = 2'b00;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] a;
        int         lat;
        int         s127;

        do_reset();
        check("rst_score0", score0, 0);
        check("rst_score1", score1, 0);
        check("rst_sat", sat, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);

        // Single request from team A
        serve(0, 2'd3);
        check("t1_score1", score1, 0);

        // Both teams held: grants must alternate A, B, A, B
        do_reset();
        pts0 = 2'd2; pts1 = 2'd1;
        model_push(0, 2); model_push(1, 1); model_push(0, 2); model_push(1, 1);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, lat);
            check("rr_wait", (lat < 12) ? 1 : 0, 1);
            pop_check(a);
        end
        req = 2'b00;
        check("rr_score0", score0, 4);
        check("rr_score1", score1, 2);

        // Saturation at 99, then a pts=0 update clears the sticky flag
        do_reset();
        for (int i = 0; i < 32; i++) serve(0, 2'd3);
        serve(0, 2'd1);
        check("pre_sat", score0, 97);
        serve(0, 2'd3);
        check("sat_score0", score0, 99);
        check("sat_flag", sat[0], 1);
        serve(0, 2'd0);
        check("sat_clear", sat[0], 0);

        // clr during ADD of a team-B request, then re-service of the held request
        pts1 = 2'd2;
        req[1] = 1'b1;
        @(negedge clk);
        check("clr_in_add_busy", busy, 1);
        check("clr_in_add_b", add_b, 2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m0 = 0; m1 = 0; msat = 2'b00;
        check("clr_ack", ack, 0);
        check("clr_busy", busy, 0);
        check("clr_score0", score0, 0);
        check("clr_score1", score1, 0);
        check("clr_sat", sat, 0);
        model_push(1, 2);
        wait_ack(a, lat);
        check("clr_reserve_lat", lat, 2);
        req[1] = 1'b0;
        pop_check(a);

        // MAX_SCORE=127 instance: carry-out forces saturation
        do_reset();
        s127 = 0;
        pts1_m = 2'd2;
        for (int i = 0; i < 64; i++) begin
            req_m[1] = 1'b1;
            @(negedge clk);
            if (i == 63) begin
                check("m_add_a", add_a_m, 126);
                check("m_add_b", add_b_m, 2);
                check("m_cout", add_cout_m, 1);
            end
            lat = 1;
            while (ack_m == 2'b00 && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check("m_ack", ack_m, 2'b10);
            req_m[1] = 1'b0;
            s127 = (s127 + 2 > 127) ? 127 : s127 + 2;
            @(negedge clk);
        end
        check("m_score1", score1_m, s127);
        check("m_sat", sat_m, 2'b10);

        // Async reset asserted while DONE is showing its ack
        do_reset();
        pts0 = 2'd1;
        req[0] = 1'b1;
        wait_ack(a, lat);
        check("ar_ack_seen", a, 2'b01);
        rst_n = 1'b0;
        #1;
        check("ar_ack", ack, 0);
        check("ar_busy", busy, 0);
        check("ar_score0", score0, 0);
        check("ar_add_a", add_a, 0);
        check("ar_add_b", add_b, 0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_idle_busy", busy, 0);
        check("ar_idle_ack", ack, 0);
        check("ar_idle_score0", score0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
